// File: rtl/rvsteel_spi_sequencer.sv
// rvsteel_spi_sequencer: runs one SPI command through the RVSteel SPI register block.
// Each command configures the mode, divider and chip select, then streams bytes.
// For every byte it writes TX, polls busy, reads RX and pushes the byte downstream.
// Finally it deselects and pulses done.
// Optional feature macro: SPI_SEQ_ABORT_EN adds i_abort, an early-terminate request.
module rvsteel_spi_sequencer #(
  parameter logic [31:0] SPI_BASE = 32'h8003_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [7:0]  i_cmd_cs,
  input  logic [7:0]  i_cmd_len,
  input  logic        i_cmd_cpol,
  input  logic        i_cmd_cpha,
  input  logic [7:0]  i_cmd_div,
  input  logic        i_tx_valid,
  output logic        o_tx_ready,
  input  logic [7:0]  i_tx_data,
  output logic        o_rx_valid,
  input  logic        i_rx_ready,
  output logic [7:0]  o_rx_data,
  output logic        o_done,
  output logic [31:0] o_m_rw_address,
  input  logic [31:0] i_m_read_data,
  output logic        o_m_read_request,
  input  logic        i_m_read_response,
  output logic [31:0] o_m_write_data,
  output logic [3:0]  o_m_write_strobe,
  output logic        o_m_write_request,
  input  logic        i_m_write_response
`ifdef SPI_SEQ_ABORT_EN
  ,
  input  logic        i_abort
`endif
);

  localparam logic [4:0] OFS_CPOL   = 5'h00;
  localparam logic [4:0] OFS_CPHA   = 5'h04;
  localparam logic [4:0] OFS_CS     = 5'h08;
  localparam logic [4:0] OFS_DIV    = 5'h0C;
  localparam logic [4:0] OFS_TX     = 5'h10;
  localparam logic [4:0] OFS_RX     = 5'h14;
  localparam logic [4:0] OFS_STATUS = 5'h18;

  typedef enum logic [3:0] {
    IDLE, CFG_CPOL, CFG_CPHA, CFG_DIV, CFG_CS, WAIT_TX, WR_TX,
    SETTLE, POLL, RD_RX, PUSH_RX, DESEL, DONE
  } state_t;

  state_t      r_state;
  logic        r_cmd_ready, r_tx_ready, r_rx_valid, r_done;
  logic [7:0]  r_rx_data, r_cs, r_len, r_div, r_tx_byte;
  logic        r_cpol, r_cpha, r_settle, r_issued;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_wreq, r_rreq;

  logic        w_bus_op, w_bus_wr, w_bus_resp, w_bus_done, w_abort;
  logic [4:0]  w_bus_ofs;
  logic [31:0] w_bus_wdata;
  logic        w_unused;

  assign w_unused = ^i_m_read_data[31:8];

`ifdef SPI_SEQ_ABORT_EN
  logic r_abort_pend;

  assign w_abort = i_abort | r_abort_pend;

  // Remember an abort seen outside the states that can act on it
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_abort_pend <= 1'b0;
    end else if (r_state == IDLE ||
                 ((r_state == WAIT_TX || r_state == PUSH_RX) && w_abort)) begin
      r_abort_pend <= 1'b0;
    end else if (i_abort) begin
      r_abort_pend <= 1'b1;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  // Bus access descriptor for the current state
  always_comb begin
    w_bus_op    = 1'b0;
    w_bus_wr    = 1'b0;
    w_bus_ofs   = 5'h00;
    w_bus_wdata = 32'h0;
    case (r_state)
      CFG_CPOL: begin w_bus_op = 1'b1; w_bus_wr = 1'b1; w_bus_ofs = OFS_CPOL; w_bus_wdata = {31'b0, r_cpol}; end
      CFG_CPHA: begin w_bus_op = 1'b1; w_bus_wr = 1'b1; w_bus_ofs = OFS_CPHA; w_bus_wdata = {31'b0, r_cpha}; end
      CFG_DIV:  begin w_bus_op = 1'b1; w_bus_wr = 1'b1; w_bus_ofs = OFS_DIV;  w_bus_wdata = {24'b0, r_div}; end
      CFG_CS:   begin w_bus_op = 1'b1; w_bus_wr = 1'b1; w_bus_ofs = OFS_CS;   w_bus_wdata = {24'b0, r_cs}; end
      WR_TX:    begin w_bus_op = 1'b1; w_bus_wr = 1'b1; w_bus_ofs = OFS_TX;   w_bus_wdata = {24'b0, r_tx_byte}; end
      POLL:     begin w_bus_op = 1'b1; w_bus_ofs = OFS_STATUS; end
      RD_RX:    begin w_bus_op = 1'b1; w_bus_ofs = OFS_RX; end
      DESEL:    begin w_bus_op = 1'b1; w_bus_wr = 1'b1; w_bus_ofs = OFS_CS;   w_bus_wdata = 32'h0000_00FF; end
      default:  ;
    endcase
  end

  assign w_bus_resp = w_bus_wr ? i_m_write_response : i_m_read_response;
  assign w_bus_done = w_bus_op & r_issued & w_bus_resp;

  // Sequencer FSM with registered handshake and bus outputs
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= 8'h00;
      r_done      <= 1'b0;
      r_cs        <= 8'h00;
      r_len       <= 8'h00;
      r_div       <= 8'h00;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_tx_byte   <= 8'h00;
      r_settle    <= 1'b0;
      r_issued    <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_wstrb     <= 4'h0;
      r_wreq      <= 1'b0;
      r_rreq      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // One-cycle request, then hold address/data until the response
      if (w_bus_op) begin
        if (!r_issued) begin
          r_issued <= 1'b1;
          r_addr   <= SPI_BASE + 32'(w_bus_ofs);
          r_wreq   <= w_bus_wr;
          r_rreq   <= ~w_bus_wr;
          if (w_bus_wr) begin
            r_wdata <= w_bus_wdata;
            r_wstrb <= 4'hF;
          end
        end else begin
          r_wreq <= 1'b0;
          r_rreq <= 1'b0;
          if (w_bus_resp) begin
            r_issued <= 1'b0;
            r_wstrb  <= 4'h0;
          end
        end
      end

      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (r_cmd_ready && i_cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_cs        <= i_cmd_cs;
            r_len       <= i_cmd_len;
            r_cpol      <= i_cmd_cpol;
            r_cpha      <= i_cmd_cpha;
            r_div       <= i_cmd_div;
            r_state     <= CFG_CPOL;
          end
        end
        CFG_CPOL: if (w_bus_done) r_state <= CFG_CPHA;
        CFG_CPHA: if (w_bus_done) r_state <= CFG_DIV;
        CFG_DIV:  if (w_bus_done) r_state <= CFG_CS;
        CFG_CS:   if (w_bus_done) r_state <= (r_len == 8'd0) ? DESEL : WAIT_TX;
        WAIT_TX: begin
          if (w_abort) begin
            r_tx_ready <= 1'b0;
            r_state    <= DESEL;
          end else if (r_tx_ready && i_tx_valid) begin
            r_tx_ready <= 1'b0;
            r_tx_byte  <= i_tx_data;
            r_state    <= WR_TX;
          end else begin
            r_tx_ready <= 1'b1;
          end
        end
        WR_TX: begin
          if (w_bus_done) begin
            r_settle <= 1'b0;
            r_state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_settle) r_state <= POLL;
          else          r_settle <= 1'b1;
        end
        POLL: if (w_bus_done && !i_m_read_data[0]) r_state <= RD_RX;
        RD_RX: begin
          if (w_bus_done) begin
            r_rx_data  <= i_m_read_data[7:0];
            r_rx_valid <= 1'b1;
            r_state    <= PUSH_RX;
          end
        end
        PUSH_RX: begin
          if (w_abort) begin
            r_rx_valid <= 1'b0;
            r_state    <= DESEL;
          end else if (r_rx_valid && i_rx_ready) begin
            r_rx_valid <= 1'b0;
            r_len      <= r_len - 8'd1;
            r_state    <= (r_len == 8'd1) ? DESEL : WAIT_TX;
          end
        end
        DESEL: begin
          if (w_bus_done) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready       = r_cmd_ready;
  assign o_tx_ready        = r_tx_ready;
  assign o_rx_valid        = r_rx_valid;
  assign o_rx_data         = r_rx_data;
  assign o_done            = r_done;
  assign o_m_rw_address    = r_addr;
  assign o_m_write_data    = r_wdata;
  assign o_m_write_strobe  = r_wstrb;
  assign o_m_write_request = r_wreq;
  assign o_m_read_request  = r_rreq;

endmodule

// File: tb/tb_rvsteel_spi_sequencer.sv
// Scoreboard bench for rvsteel_spi_sequencer with a behavioural SPI register responder.
// Build with SPI_SEQ_ABORT_EN defined to include the abort scenario.
`timescale 1ns/1ps
module tb_rvsteel_spi_sequencer;

  localparam logic [31:0] BASE = 32'h8003_0000;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_cmd_valid, o_cmd_ready;
  logic [7:0]  i_cmd_cs, i_cmd_len, i_cmd_div;
  logic        i_cmd_cpol, i_cmd_cpha;
  logic        i_tx_valid, o_tx_ready;
  logic [7:0]  i_tx_data;
  logic        o_rx_valid, i_rx_ready;
  logic [7:0]  o_rx_data;
  logic        o_done;
  logic [31:0] o_m_rw_address, i_m_read_data, o_m_write_data;
  logic        o_m_read_request, i_m_read_response;
  logic [3:0]  o_m_write_strobe;
  logic        o_m_write_request, i_m_write_response;
`ifdef SPI_SEQ_ABORT_EN
  logic        i_abort;
`endif

  always #5 clk = ~clk;

  rvsteel_spi_sequencer #(.SPI_BASE(BASE)) dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_cs(i_cmd_cs), .i_cmd_len(i_cmd_len), .i_cmd_cpol(i_cmd_cpol),
    .i_cmd_cpha(i_cmd_cpha), .i_cmd_div(i_cmd_div),
    .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready), .i_tx_data(i_tx_data),
    .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready), .o_rx_data(o_rx_data),
    .o_done(o_done),
    .o_m_rw_address(o_m_rw_address), .i_m_read_data(i_m_read_data),
    .o_m_read_request(o_m_read_request), .i_m_read_response(i_m_read_response),
    .o_m_write_data(o_m_write_data), .o_m_write_strobe(o_m_write_strobe),
    .o_m_write_request(o_m_write_request), .i_m_write_response(i_m_write_response)
`ifdef SPI_SEQ_ABORT_EN
    , .i_abort(i_abort)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_wr[$];
  logic [7:0]  exp_rx[$];
  logic [7:0]  rx_src[$];

  int poll_reads = 0, rx_reads = 0, done_cnt = 0, tx_hs = 0, ff_writes = 0;
  int poll_in_byte = 0;
  int busy_per = 0;
  int rx_stall = 0;
  logic prev_wreq = 1'b0, prev_rreq = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Responder handshake: one-cycle response the cycle after each request
  always @(posedge clk) begin
    i_m_write_response <= o_m_write_request;
    i_m_read_response  <= o_m_read_request;
  end

  // Register model, bus/stream monitors and scoreboard pops (sampled mid-cycle)
  always @(negedge clk) begin
    if (!i_reset) begin
      poll_in_byte = 0;
      prev_wreq    = 1'b0;
      prev_rreq    = 1'b0;
    end else begin
      if (o_m_read_request) begin
        if (o_m_rw_address == BASE + 32'h18) begin
          i_m_read_data = (poll_in_byte < busy_per) ? 32'h0000_0003 : 32'hFFFF_FFFE;
          poll_in_byte++;
          poll_reads++;
        end else if (o_m_rw_address == BASE + 32'h14) begin
          i_m_read_data = {24'hC3C3C3, (rx_src.size() > 0) ? rx_src.pop_front() : 8'hEE};
          poll_in_byte = 0;
          rx_reads++;
        end else begin
          check_eq("rd_addr", {32'h0, o_m_rw_address}, {32'h0, BASE + 32'h18});
        end
      end
      if (o_m_write_request) begin
        check_eq("wr_strobe", {60'h0, o_m_write_strobe}, 64'hF);
        if (o_m_rw_address == BASE + 32'h08 && o_m_write_data == 32'hFF) ff_writes++;
        if (exp_wr.size() == 0) check_eq("wr_unexpected", 64'h1, 64'h0);
        else check_eq("wr_addr_data", {o_m_rw_address, o_m_write_data}, exp_wr.pop_front());
      end
      if (prev_wreq) check_eq("wreq_pulse", {63'h0, o_m_write_request}, 64'h0);
      if (prev_rreq) check_eq("rreq_pulse", {63'h0, o_m_read_request}, 64'h0);
      prev_wreq = o_m_write_request;
      prev_rreq = o_m_read_request;
      if (o_tx_ready && i_tx_valid) tx_hs++;
      if (o_rx_valid && i_rx_ready) begin
        if (exp_rx.size() == 0) check_eq("rx_unexpected", 64'h1, 64'h0);
        else check_eq("rx_data", {56'h0, o_rx_data}, {56'h0, exp_rx.pop_front()});
      end
      if (o_done) done_cnt++;
      if (o_tx_ready || o_rx_valid)
        check_eq("stall_bus_req", {62'h0, o_m_read_request, o_m_write_request}, 64'h0);
    end
  end

  // rx consumer: holds rx_ready low for rx_stall cycles per byte
  initial begin
    int cnt;
    cnt = 0;
    i_rx_ready = 1'b0;
    forever begin
      tick();
      if (!i_reset || !o_rx_valid) begin
        i_rx_ready = 1'b0;
        cnt = 0;
      end else if (cnt >= rx_stall) begin
        i_rx_ready = 1'b1;
      end else begin
        i_rx_ready = 1'b0;
        cnt++;
      end
    end
  end

  task automatic issue_cmd(input logic [7:0] cs, input logic [7:0] len, input logic cpol,
                           input logic cpha, input logic [7:0] div);
    bit seen;
    seen = 1'b0;
    i_cmd_valid = 1'b1; i_cmd_cs = cs; i_cmd_len = len;
    i_cmd_cpol = cpol; i_cmd_cpha = cpha; i_cmd_div = div;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = o_cmd_ready;
    end
    check_eq("cmd_accept", {63'h0, seen}, 64'h1);
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic send_tx(input logic [7:0] b, input int gap);
    bit seen;
    seen = 1'b0;
    repeat (gap) tick();
    i_tx_valid = 1'b1;
    i_tx_data  = b;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      seen = o_tx_ready;
    end
    check_eq("tx_accept", {63'h0, seen}, 64'h1);
    tick();
    i_tx_valid = 1'b0;
    i_tx_data  = 8'h00;
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", {63'h0, done_cnt != base}, 64'h1);
    repeat (4) @(negedge clk);
    check_eq("done_pulses", 64'(done_cnt - base), 64'h1);
    tick();
  endtask

  task automatic push_cfg(input logic [7:0] cs, input logic cpol, input logic cpha,
                          input logic [7:0] div);
    exp_wr.push_back({BASE + 32'h00, 31'h0, cpol});
    exp_wr.push_back({BASE + 32'h04, 31'h0, cpha});
    exp_wr.push_back({BASE + 32'h0C, 24'h0, div});
    exp_wr.push_back({BASE + 32'h08, 24'h0, cs});
  endtask

  task automatic run_cmd(input logic [7:0] cs, input int len, input logic cpol, input logic cpha,
                         input logic [7:0] div, input int busy, input int gap, input int stall,
                         input logic [7:0] tx0, input logic [7:0] rx0, input bit poke_cmd);
    int d0, t0, p0, r0;
    logic [7:0] txb[$];
    d0 = done_cnt; t0 = tx_hs; p0 = poll_reads; r0 = rx_reads;
    busy_per = busy;
    rx_stall = stall;
    push_cfg(cs, cpol, cpha, div);
    for (int i = 0; i < len; i++) begin
      logic [7:0] tb_b, rb;
      tb_b = (i == 0) ? tx0 : 8'($urandom);
      rb   = (i == 0) ? rx0 : 8'($urandom);
      txb.push_back(tb_b);
      exp_wr.push_back({BASE + 32'h10, 24'h0, tb_b});
      rx_src.push_back(rb);
      exp_rx.push_back(rb);
    end
    exp_wr.push_back({BASE + 32'h08, 32'h0000_00FF});
    issue_cmd(cs, 8'(len), cpol, cpha, div);
    for (int i = 0; i < len; i++) begin
      send_tx(txb[i], gap);
      if (poke_cmd && i == 0) begin
        i_cmd_valid = 1'b1; i_cmd_cs = 8'h77; i_cmd_len = 8'd9;
        tick();
        i_cmd_valid = 1'b0;
      end
    end
    wait_done(d0);
    check_eq("tx_handshakes", 64'(tx_hs - t0), 64'(len));
    check_eq("poll_reads", 64'(poll_reads - p0), 64'(len * (busy + 1)));
    check_eq("rx_reads", 64'(rx_reads - r0), 64'(len));
    check_eq("wr_left", 64'(exp_wr.size()), 64'h0);
    check_eq("rx_left", 64'(exp_rx.size()), 64'h0);
    check_eq("cmd_ready_end", {63'h0, o_cmd_ready}, 64'h1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0, p0, n;
    i_reset = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_cs = 8'h00; i_cmd_len = 8'h00;
    i_cmd_cpol = 1'b0; i_cmd_cpha = 1'b0; i_cmd_div = 8'h00;
    i_tx_valid = 1'b0; i_tx_data = 8'h00;
    i_m_read_data = 32'h0;
`ifdef SPI_SEQ_ABORT_EN
    i_abort = 1'b0;
`endif
    repeat (3) tick();
    check_eq("rst_cmd_ready", {63'h0, o_cmd_ready}, 64'h0);
    check_eq("rst_reqs", {59'h0, o_tx_ready, o_rx_valid, o_done, o_m_read_request,
             o_m_write_request}, 64'h0);
    check_eq("rst_bus", {o_m_rw_address, o_m_write_data}, 64'h0);
    check_eq("rst_strobe_rx", {52'h0, o_m_write_strobe, o_rx_data}, 64'h0);
    i_reset = 1'b1;
    tick();
    check_eq("cmd_ready_after_rst", {63'h0, o_cmd_ready}, 64'h1);

    // Single byte, three busy polls
    run_cmd(8'h00, 1, 1'b0, 1'b0, 8'h00, 3, 0, 0, 8'hA5, 8'h3C, 1'b0);
    // Zero-length command
    run_cmd(8'h05, 0, 1'b1, 1'b0, 8'h07, 0, 0, 0, 8'h00, 8'h00, 1'b0);
    // Three bytes with tx gaps and rx backpressure, stray cmd_valid mid-transfer
    run_cmd(8'h02, 3, 1'b1, 1'b1, 8'h03, 1, 5, 4, 8'h5A, 8'h81, 1'b1);

    // Reset while polling
    busy_per = 50;
    rx_stall = 0;
    push_cfg(8'h01, 1'b0, 1'b1, 8'h10);
    exp_wr.push_back({BASE + 32'h10, 32'h0000_005E});
    rx_src.push_back(8'h11);
    p0 = poll_reads;
    issue_cmd(8'h01, 8'd1, 1'b0, 1'b1, 8'h10);
    send_tx(8'h5E, 0);
    n = 0;
    while (poll_reads == p0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("poll_reached", {63'h0, poll_reads != p0}, 64'h1);
    f0 = ff_writes;
    tick();
    i_reset = 1'b0;
    tick();
    check_eq("mid_rst_reqs", {61'h0, o_m_read_request, o_m_write_request, o_cmd_ready}, 64'h0);
    check_eq("mid_rst_bus", {o_m_rw_address, 28'h0, o_m_write_strobe}, 64'h0);
    tick();
    i_reset = 1'b1;
    rx_src.delete();
    tick();
    check_eq("cmd_ready_after_mid_rst", {63'h0, o_cmd_ready}, 64'h1);
    repeat (20) tick();
    check_eq("no_desel_on_rst", 64'(ff_writes - f0), 64'h0);
    check_eq("rst_wr_left", 64'(exp_wr.size()), 64'h0);

    // Recovery after reset
    run_cmd(8'h03, 2, 1'b0, 1'b1, 8'h01, 2, 1, 1, 8'hC7, 8'h18, 1'b0);

`ifdef SPI_SEQ_ABORT_EN
    begin
      int d0, t0, r0;
      d0 = done_cnt; t0 = tx_hs; r0 = rx_reads;
      busy_per = 0;
      rx_stall = 0;
      push_cfg(8'h04, 1'b1, 1'b1, 8'h02);
      exp_wr.push_back({BASE + 32'h10, 32'h0000_0096});
      exp_wr.push_back({BASE + 32'h08, 32'h0000_00FF});
      exp_rx.push_back(8'h6B);
      rx_src.push_back(8'h6B);
      rx_src.push_back(8'h6C);
      issue_cmd(8'h04, 8'd4, 1'b1, 1'b1, 8'h02);
      send_tx(8'h96, 0);
      n = 0;
      while (!(exp_rx.size() == 0 && o_tx_ready) && n < 500) begin
        @(negedge clk);
        n++;
      end
      check_eq("abort_wait_tx2", {63'h0, o_tx_ready}, 64'h1);
      tick();
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      wait_done(d0);
      check_eq("abort_tx_hs", 64'(tx_hs - t0), 64'h1);
      check_eq("abort_rx_reads", 64'(rx_reads - r0), 64'h1);
      check_eq("abort_wr_left", 64'(exp_wr.size()), 64'h0);
      check_eq("abort_rx_left", 64'(exp_rx.size()), 64'h0);
      rx_src.delete();
    end
`endif

    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rvsteel_spi_sequencer.md
RVSTEEL_SPI_SEQUENCER -- requirements
Module: rvsteel_spi_sequencer

Interface
REQ-001 Parameter: SPI_BASE, default 32'h80030000, base address of the SPI peripheral register block.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; 0 = reset.
REQ-004 cmd_valid / cmd_ready  input / output  1 / 1  command handshake; the command is accepted in a cycle where both are 1.
REQ-005 cmd_cs  input  8  chip-select index written to SPI_BASE+0x08.
REQ-006 cmd_len  input  8  byte count, 0..255.
REQ-007 cmd_cpol, cmd_cpha  input  1 each  SPI mode bits.
REQ-008 cmd_div  input  8  clock divider.
REQ-009 tx_valid / tx_ready / tx_data  input / output / input  1 / 1 / 8  transmit byte stream.
REQ-010 rx_valid / rx_ready / rx_data  output / input / output  1 / 1 / 8  receive byte stream.
REQ-011 done  output  1  one-cycle pulse when a command completes.
REQ-012 m_rw_address 32 out, m_read_data 32 in, m_read_request 1 out, m_read_response 1 in, m_write_data 32 out, m_write_strobe 4 out, m_write_request 1 out, m_write_response 1 in  bus master port to the SPI peripheral.

Function
REQ-013 FSM states: IDLE, CFG_CPOL, CFG_CPHA, CFG_DIV, CFG_CS, WAIT_TX, WR_TX, SETTLE, POLL, RD_RX, PUSH_RX, DESEL, DONE.
REQ-014 cmd_ready shall be 1 only in IDLE; on acceptance, cs/len/cpol/cpha/div shall be latched and the FSM shall move to CFG_CPOL.
REQ-015 Each bus access shall assert its request for exactly one cycle, hold address/data until the response, and then advance; m_write_strobe shall be 4'hF during writes and 0 otherwise.
REQ-016 The CFG states shall write {31'b0,cpol} to +0x00, {31'b0,cpha} to +0x04, {24'b0,div} to +0x0C and {24'b0,cs} to +0x08, in that order.
REQ-017 After CFG_CS: if the remaining byte count is 0, go to DESEL; otherwise go to WAIT_TX.
REQ-018 WAIT_TX shall assert tx_ready; on tx_valid, latch tx_data and go to WR_TX, which writes {24'b0,byte} to +0x10.
REQ-019 SETTLE shall idle 2 cycles after the write response, then go to POLL.
REQ-020 POLL shall read +0x18 and repeat while read_data[0]==1; on 0, go to RD_RX.
REQ-021 RD_RX shall read +0x14 and latch read_data[7:0].
REQ-022 PUSH_RX shall hold rx_valid=1 and rx_data stable until rx_ready; then decrement the count and return to WAIT_TX, or go to DESEL when the count reaches 0.
REQ-023 DESEL shall write 32'hFF to +0x08; DONE shall pulse done for one cycle and return to IDLE.
REQ-024 Backpressure: an idle tx stream or a stalled rx stream shall hold the FSM indefinitely, with no bus requests issued.
REQ-025 cmd_valid outside IDLE shall be ignored, with no queuing.

Reset
REQ-026 While reset==0 at a clock edge: state=IDLE; cmd_ready=0 during reset and 1 in the first cycle after; tx_ready, rx_valid, done, m_read_request and m_write_request =0; m_rw_address, m_write_data, m_write_strobe and rx_data =0.
REQ-027 A reset in mid-operation shall abandon the transfer without issuing a deselect write.

Configuration
REQ-028 Macro SPI_SEQ_ABORT_EN: when defined, adds input abort (1 bit).
REQ-029 With the macro defined, abort sampled high in WAIT_TX or PUSH_RX shall drop any pending rx byte and go to DESEL then DONE; abort in any other state shall be held pending until the FSM reaches one of those states.
REQ-030 With the macro undefined, the port does not exist and the behaviour is as in REQ-013..REQ-025.

Verification
REQ-031 cmd cs=0, len=1, cpol=0, cpha=0, div=0; tx 8'hA5; responder busy for 3 polls, rx=8'h3C -> writes in order +00=0, +04=0, +0C=0, +08=0, +10=A5; 3+1 reads of +18, one read of +14, rx_data=3C, write +08=FF, one done pulse.
REQ-032 len=0 -> four config writes and the deselect write only, zero tx_ready handshakes, done pulses.
REQ-033 len=3 with tx_valid gaps of 5 cycles and rx_ready held low for 4 cycles per byte -> no bus request while stalled; bytes are delivered in order.
REQ-034 reset pulled low during POLL -> all requests are 0 next cycle; no +08=FF write; cmd_ready=1 after release.
REQ-035 SPI_SEQ_ABORT_EN defined, abort asserted in WAIT_TX of byte 2 of 4 -> DESEL write +08=FF, done pulses, exactly 1 rx byte delivered.
